// File: rtl/axis_frame_arbiter_pkg.sv
// Shared state encoding and index-width helper for the AXI4-Stream frame arbiter.
// No logic, no latency, no flow control.
package axis_frame_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Never returns less than 1, so a 2-port arbiter still has a 1-bit index.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/axis_arb_rr_select.sv
// Next-winner pick: round-robin after last_grant, or lowest index in fixed mode.
// Purely combinational, zero latency.
// No backpressure; found=0 when no request is present.
module axis_arb_rr_select
    import axis_frame_arbiter_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int IDX_W = 2
) (
    input  logic [PORTS-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    input  logic             round_robin,
    output logic [IDX_W-1:0] winner,
    output logic             found
);

    int idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < PORTS; k++) begin
            idx = round_robin ? (int'(last_grant) + 1 + k) % PORTS : k;
            if (!found && req[idx]) begin
                winner = IDX_W'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis_frame_arbiter.sv
// N:1 AXI4-Stream arbiter that holds each grant until the frame's tlast is accepted.
// Latency: grant 1 cycle after tvalid, first output beat 2 cycles after tvalid.
// Backpressure: output stall drops tready only on the granted input; others always see 0.
module axis_frame_arbiter
    import axis_frame_arbiter_pkg::*;
#(
    parameter int PORTS       = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int ROUND_ROBIN = 1,
    localparam int IDX_W      = clog2(PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*DATA_WIDTH-1:0] input_axis_tdata,
    input  logic [PORTS-1:0]            input_axis_tvalid,
    output logic [PORTS-1:0]            input_axis_tready,
    input  logic [PORTS-1:0]            input_axis_tlast,
    input  logic [PORTS-1:0]            input_axis_tuser,
    output logic [DATA_WIDTH-1:0]       output_axis_tdata,
    output logic                        output_axis_tvalid,
    input  logic                        output_axis_tready,
    output logic                        output_axis_tlast,
    output logic                        output_axis_tuser,
    output logic                        grant_valid,
    output logic [IDX_W-1:0]            grant_index
);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      grant_index_q, grant_index_d;
    logic [IDX_W-1:0]      last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  tuser_q, tuser_d;

    logic [IDX_W-1:0]      winner;
    logic                  found;
    logic                  ready_int;
    logic                  accept;

    axis_arb_rr_select #(
        .PORTS (PORTS),
        .IDX_W (IDX_W)
    ) u_select (
        .req         (input_axis_tvalid),
        .last_grant  (last_grant_q),
        .round_robin (ROUND_ROBIN != 0),
        .winner      (winner),
        .found       (found)
    );

    // The output register may take a new beat when empty or draining this cycle.
    always_comb begin
        ready_int = (state_q == ACTIVE) && (output_axis_tready || !tvalid_q);
        accept    = ready_int && input_axis_tvalid[grant_index_q];
        input_axis_tready = '0;
        for (int i = 0; i < PORTS; i++) begin
            input_axis_tready[i] = ready_int && (grant_index_q == IDX_W'(i));
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_index_d = grant_index_q;
        last_grant_d  = last_grant_q;
        tdata_d       = tdata_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        tuser_d       = tuser_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_index_d = winner;
                    state_d       = ACTIVE;
                end
            end
            ACTIVE: begin
                if (accept && input_axis_tlast[grant_index_q]) begin
                    state_d      = IDLE;
                    last_grant_d = grant_index_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (output_axis_tready || !tvalid_q) begin
            tvalid_d = accept;
        end
        if (accept) begin
            tdata_d = input_axis_tdata[int'(grant_index_q)*DATA_WIDTH +: DATA_WIDTH];
            tlast_d = input_axis_tlast[grant_index_q];
            tuser_d = input_axis_tuser[grant_index_q];
        end
    end

    // Reset drops any partial frame; last_grant starts at PORTS-1 so input 0 leads.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_index_q <= '0;
            last_grant_q  <= IDX_W'(PORTS - 1);
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            tuser_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_index_q <= grant_index_d;
            last_grant_q  <= last_grant_d;
            tdata_q       <= tdata_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            tuser_q       <= tuser_d;
        end
    end

    assign output_axis_tdata  = tdata_q;
    assign output_axis_tvalid = tvalid_q;
    assign output_axis_tlast  = tlast_q;
    assign output_axis_tuser  = tuser_q;
    assign grant_valid        = (state_q == ACTIVE);
    assign grant_index        = grant_index_q;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed bench for axis_frame_arbiter: a round-robin and a fixed-priority instance.
module tb_axis_frame_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic [31:0] rr_tdata, fp_tdata;
    logic [3:0]  rr_tvalid, rr_tready, rr_tlast, rr_tuser;
    logic [3:0]  fp_tvalid, fp_tready, fp_tlast, fp_tuser;
    logic [7:0]  rr_od, fp_od;
    logic        rr_ov, rr_ordy, rr_ol, rr_ou, rr_gv;
    logic        fp_ov, fp_ordy, fp_ol, fp_ou, fp_gv;
    logic [1:0]  rr_gi, fp_gi;

    logic [3:0]  rr_hs, fp_hs, rr_pre_rdy, fp_pre_rdy;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    axis_frame_arbiter #(.PORTS(4), .DATA_WIDTH(8), .ROUND_ROBIN(1)) dut_rr (
        .clk(clk), .rst(rst),
        .input_axis_tdata(rr_tdata), .input_axis_tvalid(rr_tvalid),
        .input_axis_tready(rr_tready), .input_axis_tlast(rr_tlast),
        .input_axis_tuser(rr_tuser),
        .output_axis_tdata(rr_od), .output_axis_tvalid(rr_ov),
        .output_axis_tready(rr_ordy), .output_axis_tlast(rr_ol),
        .output_axis_tuser(rr_ou),
        .grant_valid(rr_gv), .grant_index(rr_gi)
    );

    axis_frame_arbiter #(.PORTS(4), .DATA_WIDTH(8), .ROUND_ROBIN(0)) dut_fp (
        .clk(clk), .rst(rst),
        .input_axis_tdata(fp_tdata), .input_axis_tvalid(fp_tvalid),
        .input_axis_tready(fp_tready), .input_axis_tlast(fp_tlast),
        .input_axis_tuser(fp_tuser),
        .output_axis_tdata(fp_od), .output_axis_tvalid(fp_ov),
        .output_axis_tready(fp_ordy), .output_axis_tlast(fp_ol),
        .output_axis_tuser(fp_ou),
        .grant_valid(fp_gv), .grant_index(fp_gi)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Capture pre-edge handshakes/readies, then move to 1 time unit after the edge.
    task automatic step();
        #1;
        rr_hs      = rr_tready & rr_tvalid;
        fp_hs      = fp_tready & fp_tvalid;
        rr_pre_rdy = rr_tready;
        fp_pre_rdy = fp_tready;
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [3:0]  vld;
        logic [3:0]  last;
        logic [3:0]  usr;
        logic [31:0] dat;
        logic        ordy;
        logic [3:0]  e_rdy;
        logic        e_gv;
        logic [1:0]  e_gi;
        logic        e_ov;
        logic [7:0]  e_od;
        logic        e_ol;
        logic        e_ou;
    } vec_t;

    vec_t tbl [18];

    int   rr_beat [4];
    int   fp_beat [4];
    int   rr_frames, fp_frames, fp_grants, low_run, out_phase, out_frame, drain, b;
    int   rr_order [$];
    logic rr_stop, fp_stop, rr_gv_prev, fp_gv_prev, seen_first;
    logic [3:0] out_port;

    task automatic set_src();
        for (int i = 0; i < 4; i++) begin
            rr_tdata[i*8 +: 8] = 8'(i*16 + rr_beat[i]);
            rr_tlast[i]        = (rr_beat[i] == 1);
            rr_tvalid[i]       = !rr_stop;
            fp_tdata[i*8 +: 8] = 8'(i*16 + fp_beat[i]);
            fp_tlast[i]        = (fp_beat[i] == 1);
            fp_tvalid[i]       = !fp_stop;
        end
    endtask

    initial begin
        //          vld     last    usr     dat           ordy  e_rdy   gv    gi     ov    od     ol    ou
        tbl[0]  = '{4'b0100, 4'b0000, 4'b0000, 32'h0011_0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{4'b0100, 4'b0000, 4'b0000, 32'h0011_0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 8'h11, 1'b0, 1'b0};
        tbl[2]  = '{4'b0100, 4'b0000, 4'b0000, 32'h0022_0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1, 8'h22, 1'b0, 1'b0};
        tbl[3]  = '{4'b0100, 4'b0100, 4'b0000, 32'h0033_0000, 1'b1, 4'b0100, 1'b0, 2'd2, 1'b1, 8'h33, 1'b1, 1'b0};
        tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0, 8'h33, 1'b1, 1'b0};
        tbl[5]  = '{4'b0010, 4'b0000, 4'b0000, 32'h0000_A100, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b0, 8'h33, 1'b1, 1'b0};
        tbl[6]  = '{4'b0010, 4'b0000, 4'b0000, 32'h0000_A100, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 8'hA1, 1'b0, 1'b0};
        tbl[7]  = '{4'b0010, 4'b0000, 4'b0000, 32'h0000_A200, 1'b0, 4'b0000, 1'b1, 2'd1, 1'b1, 8'hA1, 1'b0, 1'b0};
        for (int r = 8; r < 12; r++) tbl[r] = tbl[7];
        tbl[12] = '{4'b0010, 4'b0000, 4'b0000, 32'h0000_A200, 1'b1, 4'b0010, 1'b1, 2'd1, 1'b1, 8'hA2, 1'b0, 1'b0};
        tbl[13] = '{4'b0010, 4'b0010, 4'b0000, 32'h0000_A300, 1'b1, 4'b0010, 1'b0, 2'd1, 1'b1, 8'hA3, 1'b1, 1'b0};
        tbl[14] = '{4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 8'hA3, 1'b1, 1'b0};
        tbl[15] = '{4'b1000, 4'b1000, 4'b1000, 32'h5A00_0000, 1'b1, 4'b0000, 1'b1, 2'd3, 1'b0, 8'hA3, 1'b1, 1'b0};
        tbl[16] = '{4'b1000, 4'b1000, 4'b1000, 32'h5A00_0000, 1'b1, 4'b1000, 1'b0, 2'd3, 1'b1, 8'h5A, 1'b1, 1'b1};
        tbl[17] = '{4'b0000, 4'b0000, 4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0, 8'h5A, 1'b1, 1'b1};

        rst = 1'b1;
        rr_tdata = '0; rr_tvalid = '0; rr_tlast = '0; rr_tuser = '0; rr_ordy = 1'b1;
        fp_tdata = '0; fp_tvalid = '0; fp_tlast = '0; fp_tuser = '0; fp_ordy = 1'b1;
        step();
        step();
        chk("reset ov", rr_ov, 0);
        chk("reset od", rr_od, 0);
        chk("reset ol", rr_ol, 0);
        chk("reset ou", rr_ou, 0);
        chk("reset gv", rr_gv, 0);
        chk("reset gi", rr_gi, 0);
        chk("reset tready", rr_tready, 0);
        chk("reset fp gv", fp_gv, 0);
        chk("reset fp gi", fp_gi, 0);
        rst = 1'b0;
        step();

        // Frame from input 2, backpressured frame from input 1, single-beat tuser frame from input 3.
        for (int r = 0; r < 18; r++) begin
            rr_tvalid = tbl[r].vld;
            rr_tlast  = tbl[r].last;
            rr_tuser  = tbl[r].usr;
            rr_tdata  = tbl[r].dat;
            rr_ordy   = tbl[r].ordy;
            step();
            chk($sformatf("row%0d tready", r), rr_pre_rdy, tbl[r].e_rdy);
            chk($sformatf("row%0d grant_valid", r), rr_gv, tbl[r].e_gv);
            chk($sformatf("row%0d grant_index", r), rr_gi, tbl[r].e_gi);
            chk($sformatf("row%0d out_tvalid", r), rr_ov, tbl[r].e_ov);
            chk($sformatf("row%0d out_tdata", r), rr_od, tbl[r].e_od);
            chk($sformatf("row%0d out_tlast", r), rr_ol, tbl[r].e_ol);
            chk($sformatf("row%0d out_tuser", r), rr_ou, tbl[r].e_ou);
        end

        // All inputs continuously offer 2-beat frames to both instances.
        rr_tuser = '0; rr_ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rr_beat[i] = 0;
            fp_beat[i] = 0;
        end
        rr_frames = 0; fp_frames = 0; fp_grants = 0; low_run = 0;
        out_phase = 0; out_frame = 0; drain = 0; out_port = '0;
        rr_stop = 1'b0; fp_stop = 1'b0; rr_gv_prev = 1'b0; fp_gv_prev = 1'b0; seen_first = 1'b0;
        set_src();
        for (int cyc = 0; cyc < 80 && drain < 3; cyc++) begin
            step();
            chk("fp nongranted tready", fp_pre_rdy[3:1], 0);
            if (rr_gv && !rr_gv_prev) begin
                rr_order.push_back(int'(rr_gi));
                if (seen_first) chk("rr idle gap", low_run, 1);
                seen_first = 1'b1;
                low_run = 0;
            end else if (!rr_gv && seen_first) begin
                low_run++;
            end
            rr_gv_prev = rr_gv;
            if (rr_ov) begin
                if (out_phase == 0) begin
                    out_port = rr_od[7:4];
                    chk("rr out port", rr_od[7:4],
                        (out_frame < rr_order.size()) ? rr_order[out_frame] : 99);
                end else begin
                    chk("rr no interleave", rr_od[7:4], out_port);
                end
                chk("rr beat number", rr_od[3:0], out_phase);
                chk("rr out tlast", rr_ol, out_phase);
                if (out_phase == 1) out_frame++;
                out_phase = 1 - out_phase;
            end
            if (fp_gv && !fp_gv_prev) begin
                chk("fp grant index", fp_gi, 0);
                fp_grants++;
            end
            fp_gv_prev = fp_gv;
            for (int i = 0; i < 4; i++) begin
                if (rr_hs[i]) begin
                    if (rr_beat[i] == 1) begin rr_beat[i] = 0; rr_frames++; end
                    else rr_beat[i] = 1;
                end
                if (fp_hs[i]) begin
                    if (fp_beat[i] == 1) begin fp_beat[i] = 0; fp_frames++; end
                    else fp_beat[i] = 1;
                end
            end
            if (rr_frames >= 5) rr_stop = 1'b1;
            if (fp_frames >= 3) fp_stop = 1'b1;
            if (rr_stop && fp_stop) drain++;
            set_src();
        end
        chk("continuous finished in budget", drain, 3);
        chk("rr grant count", rr_order.size(), 5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("rr grant order %0d", k),
                (k < rr_order.size()) ? rr_order[k] : 99, k % 4);
        end
        chk("rr output frames", out_frame, 5);
        chk("fp grants", fp_grants, 3);

        // Complete a frame from input 2 so a stale last_grant would favour input 3.
        rr_tvalid = 4'b0100; rr_tlast = 4'b0100; rr_tdata = 32'h0066_0000;
        step();
        chk("pre-reset grant index", rr_gi, 2);
        step();
        rr_tvalid = 4'b0000;
        step();

        // Reset after beat 2 of a 4-beat frame from input 2.
        b = 0;
        rr_tvalid = 4'b0100; rr_tlast = 4'b0000; rr_tdata = 32'h00C0_0000;
        for (int cyc = 0; cyc < 20 && b < 2; cyc++) begin
            step();
            if (rr_hs[2]) begin
                b++;
                rr_tdata = {8'h00, 8'(8'hC0 + b), 16'h0000};
                rr_tlast = (b == 3) ? 4'b0100 : 4'b0000;
            end
        end
        chk("mid-frame beats accepted", b, 2);
        chk("mid-frame out data", rr_od, 8'hC1);
        rst = 1'b1;
        rr_tvalid = 4'b0000;
        step();
        rst = 1'b0;
        chk("abort ov", rr_ov, 0);
        chk("abort gv", rr_gv, 0);
        chk("abort od", rr_od, 0);
        chk("abort ol", rr_ol, 0);
        chk("abort tready", rr_tready, 0);
        rr_tvalid = 4'b1010; rr_tlast = 4'b1010; rr_tdata = 32'h7300_7100;
        step();
        chk("post-reset gv", rr_gv, 1);
        chk("post-reset gi", rr_gi, 1);
        step();
        rr_tvalid = 4'b0000;
        chk("post-reset ov", rr_ov, 1);
        chk("post-reset od", rr_od, 8'h71);
        chk("post-reset ol", rr_ol, 1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
